// File: rtl/rv_dmem_resp_if.sv
// Data-memory request/response bus between the multicycle core (master)
// and the data-memory responder (slave).
interface rv_dmem_resp_if #(
  parameter int DPWIDTH = 32
);
  logic                   req;
  logic                   we;
  logic [DPWIDTH-1:0]     addr;
  logic [DPWIDTH-1:0]     wdata;
  logic [DPWIDTH/8-1:0]   be;
  logic [DPWIDTH-1:0]     rdata;
  logic                   ack;
  logic                   err;
  logic                   busy;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/rv_dmem_resp.sv
// Word-wide data-memory responder with programmable wait states and error responses.
// Optional MMIO output register at word address 0xFFFF_FFF0 when DMEM_MMIO_EN is defined.
module rv_dmem_resp #(
  parameter int DPWIDTH = 32,
  parameter int DEPTH   = 256,
  parameter int WAIT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  rv_dmem_resp_if.slave     bus
`ifdef DMEM_MMIO_EN
  ,
  output logic [DPWIDTH-1:0] mmio_out
`endif
);

  localparam int                 BEW     = DPWIDTH / 8;
  localparam int                 IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DPWIDTH-1:0] DEPTH_W = DPWIDTH'(DEPTH);
  localparam logic [3:0]         WAIT_LD = 4'(WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [DPWIDTH-1:0] wdata_q, wdata_d;
  logic [BEW-1:0]     be_q, be_d;
  logic               sel_q, sel_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [DPWIDTH-1:0] rdata_q, rdata_d;

  logic               mmio_hit_s;
  logic               addr_err_s;
  logic               acc_fire_s;
  logic               acc_we_s;
  logic [IDXW-1:0]    acc_idx_s;
  logic [DPWIDTH-1:0] acc_wdata_s;
  logic [BEW-1:0]     acc_be_s;
  logic               acc_mmio_s;
  logic               mem_we_s;

  logic [DPWIDTH-1:0] mem [DEPTH];

`ifdef DMEM_MMIO_EN
  localparam logic [DPWIDTH-1:0] MMIO_ADDR = {{(DPWIDTH-4){1'b1}}, 4'h0};

  logic [DPWIDTH-1:0] mmio_q, mmio_d;

  function automatic logic [DPWIDTH-1:0] merge_be(input logic [DPWIDTH-1:0] old_v,
                                                  input logic [DPWIDTH-1:0] new_v,
                                                  input logic [BEW-1:0]     en);
    logic [DPWIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < BEW; i++) begin
      if (en[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign mmio_hit_s = (bus.addr == MMIO_ADDR);
  assign mmio_out   = mmio_q;
`else
  assign mmio_hit_s = 1'b0;
`endif

  // The MMIO word sits far above the array and is exempt from the range check.
  assign addr_err_s = (bus.addr[1:0] != 2'b00) ||
                      (({2'b00, bus.addr[DPWIDTH-1:2]} >= DEPTH_W) && !mmio_hit_s);

  // Next-state, capture and access-operand selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    sel_d       = sel_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    acc_fire_s  = 1'b0;
    acc_we_s    = we_q;
    acc_idx_s   = idx_q;
    acc_wdata_s = wdata_q;
    acc_be_s    = be_q;
    acc_mmio_s  = sel_q;
`ifdef DMEM_MMIO_EN
    mmio_d      = mmio_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          idx_d   = bus.addr[IDXW+1:2];
          wdata_d = bus.wdata;
          be_d    = bus.be;
          sel_d   = mmio_hit_s;
          if (addr_err_s) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else if (WAIT == 0) begin
            // Zero wait states: the access happens on the accept edge itself.
            state_d     = S_RESP;
            ack_d       = 1'b1;
            acc_fire_s  = 1'b1;
            acc_we_s    = bus.we;
            acc_idx_s   = bus.addr[IDXW+1:2];
            acc_wdata_s = bus.wdata;
            acc_be_s    = bus.be;
            acc_mmio_s  = mmio_hit_s;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          ack_d      = 1'b1;
          acc_fire_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (acc_fire_s && !acc_we_s) begin
`ifdef DMEM_MMIO_EN
      if (acc_mmio_s) begin
        rdata_d = mmio_q;
      end else begin
        rdata_d = mem[acc_idx_s];
      end
`else
      rdata_d = mem[acc_idx_s];
`endif
    end else begin
      rdata_d = rdata_q;
    end

`ifdef DMEM_MMIO_EN
    if (acc_fire_s && acc_we_s && acc_mmio_s) begin
      mmio_d = merge_be(mmio_q, acc_wdata_s, acc_be_s);
    end else begin
      mmio_d = mmio_q;
    end
`endif
  end

  // A write still in flight when reset arrives must not reach the array.
  assign mem_we_s = acc_fire_s && acc_we_s && !acc_mmio_s && !rst;

  // Array write port with per-byte enables; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < BEW; i++) begin
        if (acc_be_s[i]) begin
          mem[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Control, captured request and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      sel_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef DMEM_MMIO_EN
      mmio_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef DMEM_MMIO_EN
      mmio_q  <= mmio_d;
`endif
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Directed self-checking bench for rv_dmem_resp (DPWIDTH=32, DEPTH=256, WAIT=2).
module tb_rv_dmem_resp;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rv_dmem_resp_if #(.DPWIDTH(32)) bus ();

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_out;
  logic [31:0] mmio_at_ack;
  rv_dmem_resp #(.DPWIDTH(32), .DEPTH(256), .WAIT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .mmio_out(mmio_out));
`else
  rv_dmem_resp #(.DPWIDTH(32), .DEPTH(256), .WAIT(2)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction from IDLE; lat is the cycle (1 = cycle after accept edge) holding ack.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output int lat, output logic e,
                     output int busy_n, output logic [31:0] rd);
    lat = 0; e = 1'bx; busy_n = 0; rd = 'x;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.we = ~w; bus.addr = 32'hFFFF_FFFC; bus.wdata = 32'h5A5A_5A5A; bus.be = 4'hF;
    for (int k = 1; k <= 20; k++) begin
      if (bus.busy) busy_n++;
      if (bus.ack) begin
        lat = k; e = bus.err; rd = bus.rdata;
`ifdef DMEM_MMIO_EN
        mmio_at_ack = mmio_out;
`endif
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  int          lat, busy_n, acks, first_k, second_k, ack_seen;
  logic        e;
  logic [31:0] rd;

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.be = 4'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, bus.ack}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
`ifdef DMEM_MMIO_EN
    check("rst_mmio", mmio_out, 32'h0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, e, busy_n, rd);
    check("wr_lat", lat, 32'd3);
    check("wr_err", {31'd0, e}, 32'd0);
    check("wr_busy", busy_n, 32'd3);
    check("wr_idle", {31'd0, bus.busy}, 32'd0);

    txn(1'b0, 32'h10, 32'h0, 4'h0, lat, e, busy_n, rd);
    check("rd_lat", lat, 32'd3);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_err", {31'd0, e}, 32'd0);
    check("rd_busy", busy_n, 32'd3);

    txn(1'b1, 32'h10, 32'h0000_1200, 4'b0010, lat, e, busy_n, rd);
    check("pw_err", {31'd0, e}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, lat, e, busy_n, rd);
    check("pw_data", rd, 32'hDEAD_12EF);

    txn(1'b0, 32'h12, 32'h0, 4'h0, lat, e, busy_n, rd);
    check("mis_lat", lat, 32'd1);
    check("mis_err", {31'd0, e}, 32'd1);
    check("mis_rdata", rd, 32'hDEAD_12EF);
    txn(1'b0, 32'h400, 32'h0, 4'h0, lat, e, busy_n, rd);
    check("oor_err", {31'd0, e}, 32'd1);
    check("oor_rdata", rd, 32'hDEAD_12EF);
    txn(1'b1, 32'h12, 32'h0, 4'hF, lat, e, busy_n, rd);
    check("miswr_err", {31'd0, e}, 32'd1);
    txn(1'b0, 32'h10, 32'h0, 4'h0, lat, e, busy_n, rd);
    check("miswr_keep", rd, 32'hDEAD_12EF);
    check("miswr_rerr", {31'd0, e}, 32'd0);

    txn(1'b1, 32'h10, 32'h0, 4'h0, lat, e, busy_n, rd);
    check("be0_lat", lat, 32'd3);
    check("be0_err", {31'd0, e}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, lat, e, busy_n, rd);
    check("be0_keep", rd, 32'hDEAD_12EF);

    // req held high across two reads
    acks = 0; first_k = 0; second_k = 0;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10; bus.be = 4'h0;
    @(posedge clk); #1;
    for (int k = 1; k <= 14; k++) begin
      if (bus.ack) begin
        acks++;
        if (acks == 1) first_k = k;
        else if (acks == 2) second_k = k;
      end
      if (k == 8) bus.req = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_acks", acks, 32'd2);
    check("b2b_first", first_k, 32'd3);
    check("b2b_second", second_k, 32'd7);
    check("b2b_rdata", bus.rdata, 32'hDEAD_12EF);

    txn(1'b1, 32'h20, 32'h1234_5678, 4'hF, lat, e, busy_n, rd);
    check("pre_wr_err", {31'd0, e}, 32'd0);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'h1111_1111; bus.be = 4'hF;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ack", {31'd0, bus.ack}, 32'd0);
    check("mid_rst_err", {31'd0, bus.err}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_rdata", bus.rdata, 32'h0);
    ack_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.ack) ack_seen++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.ack) ack_seen++;
    end
    check("mid_no_ack", ack_seen, 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, lat, e, busy_n, rd);
    check("mid_rd_data", rd, 32'h1234_5678);
    check("mid_rd_lat", lat, 32'd3);

`ifdef DMEM_MMIO_EN
    txn(1'b1, 32'hFFFF_FFF0, 32'h0000_00A5, 4'hF, lat, e, busy_n, rd);
    check("mmio_wr_err", {31'd0, e}, 32'd0);
    check("mmio_wr_lat", lat, 32'd3);
    check("mmio_at_ack", mmio_at_ack, 32'h0000_00A5);
    txn(1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0, lat, e, busy_n, rd);
    check("mmio_rd_data", rd, 32'h0000_00A5);
    check("mmio_rd_err", {31'd0, e}, 32'd0);
`else
    txn(1'b1, 32'hFFFF_FFF0, 32'h0000_00A5, 4'hF, lat, e, busy_n, rd);
    check("nommio_err", {31'd0, e}, 32'd1);
    check("nommio_lat", lat, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rv_dmem_resp.md
Name: rv_dmem_resp

Overview:
- Data-memory responder for the multicycle RISC-V core. It is the memory-side end of the core's data-memory interface.
- Accepts one word request at a time: a read, or a byte-enabled write.
- Inserts a configurable number of wait states, then returns the read data or the write completion with a one-cycle ack.
- Flags misaligned and out-of-range accesses with an error response instead of touching the array.

Parameters:
- DPWIDTH, 32, data/address width in bits (byte-enable width is DPWIDTH/8).
- DEPTH, 256, number of words in the array; legal word index 0..DEPTH-1.
- WAIT, 2, wait states between request accept and ack; legal range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req  input  1  request strobe; sampled only in IDLE
- we  input  1  1 = write, 0 = read; sampled with req
- addr  input  DPWIDTH  byte address; sampled with req
- wdata  input  DPWIDTH  write data; sampled with req
- be  input  DPWIDTH/8  byte enables for writes; bit i enables byte i (bits 8i+7:8i); ignored for reads
- rdata  output  DPWIDTH  read data; valid in the ack cycle and held until the next ack
- ack  output  1  one-cycle completion pulse
- err  output  1  error flag; valid only with ack
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous): state IDLE, ack=0, err=0, rdata=0, busy=0, wait counter=0, captured request regs=0. Array contents are not reset and are undefined until written.
- States: IDLE, WAIT, RESP.
- IDLE, req=1: capture we/addr/wdata/be on that edge. Error check: addr[1:0]!=0 OR addr[DPWIDTH-1:2]>=DEPTH.
  - Error: next state RESP with err pending. No array access.
  - No error and WAIT=0: next state RESP, access performed on this same edge.
  - No error and WAIT>0: next state WAIT, counter loaded with WAIT-1.
- IDLE, req=0: stay in IDLE.
- WAIT: counter decrements each cycle. When counter==0: perform the access and go to RESP on that edge.
- Access timing:
  - Read: rdata <= mem[index] on the transition into RESP.
  - Write: mem[index] bytes with be=1 are updated on that edge; bytes with be=0 are preserved. rdata is unchanged on writes.
- RESP: ack=1 and err=pending error for exactly one cycle, then unconditionally return to IDLE.
  - req during WAIT or RESP is ignored, not queued.
  - A new request is accepted earliest in the cycle after ack (the IDLE cycle).
- Latency: the req-accept edge to ack high is WAIT+1 cycles. Peak throughput is one access per WAIT+2 cycles.
- Error response: ack=1, err=1, rdata unchanged, array unchanged.
- Captured request is stable for the whole transaction. Input changes after accept have no effect.
- be=0 write: completes with ack, err=0, and no array change.
- Reset mid-transaction: abort immediately to IDLE. A pending write is not performed and ack is never issued.
- Outputs ack/err/busy are registered or decoded from state only, with no combinational path from req.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - Adds output port mmio_out (DPWIDTH, reset 0).
  - Word address DPWIDTH'hFFFF_FFF0 is a legal MMIO register, exempt from the range check.
  - Writes update mmio_out per be, on the same edge as an array write.
  - Reads return mmio_out.
  - Same wait/ack timing as array accesses.
- Not defined: no mmio_out port. 0xFFFF_FFF0 is out of range and returns err=1.

Test Plan:
- WAIT=2: write addr=0x10, wdata=0xDEADBEEF, be=4'hF, then read addr=0x10 -> each ack exactly 3 cycles after accept edge, rdata=0xDEADBEEF, err=0, busy high for 3 cycles per transaction.
- Partial write: after above, write addr=0x10, wdata=0x00001200, be=4'b0010, then read -> rdata=0xDEAD12EF.
- Errors: read addr=0x12 (misaligned) and read addr=4*DEPTH=0x400 -> ack with err=1, rdata retains previous 0xDEAD12EF, array word 0x10 unchanged.
- Back-to-back: req held high continuously for two reads -> second request accepted only in IDLE cycle after first ack; req pulses during WAIT/RESP produce no extra acks.
- Reset mid-op: start write addr=0x20, wdata=0x11111111, assert rst during WAIT, then read 0x20 after reset -> no ack before reset; read returns value previously stored (not 0x11111111); all outputs 0 during reset.
- DMEM_MMIO_EN defined: write 0xFFFF_FFF0 wdata=0x0000_00A5 be=4'hF -> mmio_out=0xA5 on ack edge, err=0; read back rdata=0xA5; undefined build: same write -> err=1.
